// File: rtl/cache_refill_ctrl_if.sv
// Memory-bus side of the refill controller: victim writeback, line-read request and read return.
interface cache_refill_ctrl_if;
    logic        wb_addr_valid;
    logic [31:0] wb_addr;
    logic        wb_addr_ready;
    logic        wb_data_valid;
    logic [31:0] wb_data;
    logic        wb_data_last;
    logic        wb_data_ready;
    logic        rd_req_valid;
    logic [31:0] rd_req_addr;
    logic        rd_req_ready;
    logic        ret_valid;
    logic [31:0] ret_data;
    logic        ret_last;

    modport master (
        output wb_addr_valid, wb_addr, wb_data_valid, wb_data, wb_data_last,
               rd_req_valid, rd_req_addr,
        input  wb_addr_ready, wb_data_ready, rd_req_ready, ret_valid, ret_data, ret_last
    );

    modport slave (
        input  wb_addr_valid, wb_addr, wb_data_valid, wb_data, wb_data_last,
               rd_req_valid, rd_req_addr,
        output wb_addr_ready, wb_data_ready, rd_req_ready, ret_valid, ret_data, ret_last
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache miss handler: captures the PLRU victim, writes it back if dirty, refills the line
// from the memory bus and marks the refilled way most-recently-used.
module cache_refill_ctrl #(
    parameter int ASSOC_NUM    = 2,
    parameter int LINE_WORDS   = 8,
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 5,
    parameter int TAG_WIDTH    = 20,
    localparam int WAY_W       = $clog2(ASSOC_NUM),
    localparam int CNT_W       = $clog2(LINE_WORDS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss_valid,
    input  logic [31:0]              miss_addr,
    output logic                     miss_ready,
    input  logic [WAY_W-1:0]         plru,
    input  logic [TAG_WIDTH-1:0]     victim_tag,
    input  logic                     victim_dirty,
    input  logic [LINE_WORDS*32-1:0] victim_line,
    cache_refill_ctrl_if.master      bus,
    output logic                     refill_we,
    output logic [WAY_W-1:0]         refill_way,
    output logic [INDEX_WIDTH-1:0]   refill_index,
    output logic [CNT_W-1:0]         refill_word,
    output logic [31:0]              refill_data,
    output logic                     tag_we,
    output logic                     repl_update,
    output logic [ASSOC_NUM-1:0]     repl_hit
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WB_ADDR = 3'd1;
    localparam logic [2:0] WB_DATA = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   cnt_last;
    logic [WAY_W-1:0]       way_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [TAG_WIDTH-1:0]   vtag_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [31:0]            line_q [LINE_WORDS];

    assign cnt_last = (cnt == CNT_W'(LINE_WORDS - 1));
    assign cnt_inc  = cnt_last ? '0 : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (miss_valid)
                        state <= victim_dirty ? WB_ADDR : RD_REQ;
                end
                WB_ADDR: begin
                    cnt <= '0;
                    if (bus.wb_addr_ready)
                        state <= WB_DATA;
                end
                WB_DATA: begin
                    if (bus.wb_data_ready) begin
                        cnt <= cnt_inc;
                        if (cnt_last)
                            state <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    cnt <= '0;
                    if (bus.rd_req_ready)
                        state <= RD_DATA;
                end
                RD_DATA: begin
                    if (bus.ret_valid) begin
                        cnt <= cnt_inc;
                        if (bus.ret_last)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Miss context is captured once on acceptance and held for the whole transaction.
    always_ff @(posedge clk) begin
        if (state == IDLE && miss_valid) begin
            way_q   <= plru;
            tag_q   <= miss_addr[31 -: TAG_WIDTH];
            index_q <= miss_addr[OFFSET_WIDTH +: INDEX_WIDTH];
            vtag_q  <= victim_tag;
            for (int unsigned i = 0; i < LINE_WORDS; i++)
                line_q[i] <= victim_line[i*32 +: 32];
        end
    end

    assign miss_ready        = (state == IDLE);

    assign bus.wb_addr_valid = (state == WB_ADDR);
    assign bus.wb_addr       = {vtag_q, index_q, {OFFSET_WIDTH{1'b0}}};
    assign bus.wb_data_valid = (state == WB_DATA);
    assign bus.wb_data       = line_q[cnt];
    assign bus.wb_data_last  = (state == WB_DATA) && cnt_last;
    assign bus.rd_req_valid  = (state == RD_REQ);
    assign bus.rd_req_addr   = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};

    assign refill_we    = (state == RD_DATA) && bus.ret_valid;
    assign refill_way   = way_q;
    assign refill_index = index_q;
    assign refill_word  = cnt;
    assign refill_data  = bus.ret_data;
    assign tag_we       = refill_we && bus.ret_last;

    assign repl_update  = (state == DONE);
    assign repl_hit     = (state == DONE) ? ({{(ASSOC_NUM-1){1'b0}}, 1'b1} << way_q) : '0;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: 2-way DUT plus a 4-way instance run in lockstep.
module tb_cache_refill_ctrl;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             miss_valid = 1'b0;
    logic [31:0]      miss_addr = '0;
    logic             plru = 1'b0;
    logic [1:0]       plru4 = '0;
    logic [19:0]      victim_tag = '0;
    logic             victim_dirty = 1'b0;
    logic [LW*32-1:0] victim_line = '0;

    logic        miss_ready, refill_we, refill_way, tag_we, repl_update;
    logic [6:0]  refill_index;
    logic [2:0]  refill_word;
    logic [31:0] refill_data;
    logic [1:0]  repl_hit;

    logic        miss_ready4, refill_we4, tag_we4, repl_update4;
    logic [1:0]  refill_way4;
    logic [6:0]  refill_index4;
    logic [2:0]  refill_word4;
    logic [31:0] refill_data4;
    logic [3:0]  repl_hit4;

    cache_refill_ctrl_if bus();
    cache_refill_ctrl_if bus4();
    assign bus4.wb_addr_ready = bus.wb_addr_ready;
    assign bus4.wb_data_ready = bus.wb_data_ready;
    assign bus4.rd_req_ready  = bus.rd_req_ready;
    assign bus4.ret_valid     = bus.ret_valid;
    assign bus4.ret_data      = bus.ret_data;
    assign bus4.ret_last      = bus.ret_last;

    cache_refill_ctrl #(.ASSOC_NUM(2), .LINE_WORDS(LW), .INDEX_WIDTH(7), .OFFSET_WIDTH(5), .TAG_WIDTH(20)) dut (
        .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .plru(plru), .victim_tag(victim_tag), .victim_dirty(victim_dirty), .victim_line(victim_line),
        .bus(bus), .refill_we(refill_we), .refill_way(refill_way), .refill_index(refill_index),
        .refill_word(refill_word), .refill_data(refill_data), .tag_we(tag_we),
        .repl_update(repl_update), .repl_hit(repl_hit)
    );

    cache_refill_ctrl #(.ASSOC_NUM(4), .LINE_WORDS(LW), .INDEX_WIDTH(7), .OFFSET_WIDTH(5), .TAG_WIDTH(20)) dut4 (
        .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready4),
        .plru(plru4), .victim_tag(victim_tag), .victim_dirty(victim_dirty), .victim_line(victim_line),
        .bus(bus4), .refill_we(refill_we4), .refill_way(refill_way4), .refill_index(refill_index4),
        .refill_word(refill_word4), .refill_data(refill_data4), .tag_we(tag_we4),
        .repl_update(repl_update4), .repl_hit(repl_hit4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input logic [127:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got 0x%0h, nothing was expected", name, act);
    endtask

    // Expected transactions, pushed at issue time and consumed by the monitor.
    logic [31:0] exp_wb_addr [$];
    logic [32:0] exp_wb_beat [$];
    logic [31:0] exp_rd      [$];
    logic [43:0] exp_refill  [$];
    logic [1:0]  exp_hit     [$];
    logic [3:0]  exp_hit4    [$];
    logic [1:0]  exp_way4 = '0;

    int rd_count = 0;
    int wb_count = 0;

    // Monitor: samples on the falling edge, between the bench's drive point and the next capture edge.
    logic        pend_wa = 1'b0, pend_wd = 1'b0, pend_rd = 1'b0;
    logic [31:0] hold_wa, hold_rd;
    logic [32:0] hold_wd;
    int          lat = 0;

    always @(negedge clk) begin
        if (reset) begin
            pend_wa = 1'b0;
            pend_wd = 1'b0;
            pend_rd = 1'b0;
            lat     = 0;
        end else begin
            if (pend_wa) check("wb_addr_hold", {bus.wb_addr_valid, bus.wb_addr}, {1'b1, hold_wa});
            if (pend_wd) check("wb_data_hold", {bus.wb_data_valid, bus.wb_data_last, bus.wb_data}, {1'b1, hold_wd});
            if (pend_rd) check("rd_req_hold", {bus.rd_req_valid, bus.rd_req_addr}, {1'b1, hold_rd});

            if (bus.wb_addr_valid && bus.wb_addr_ready) begin
                if (exp_wb_addr.size() > 0) check("wb_addr", bus.wb_addr, exp_wb_addr.pop_front());
                else extra("wb_addr_unexpected", bus.wb_addr);
            end
            pend_wa = bus.wb_addr_valid && !bus.wb_addr_ready;
            hold_wa = bus.wb_addr;

            if (bus.wb_data_valid && bus.wb_data_ready) begin
                wb_count++;
                if (exp_wb_beat.size() > 0)
                    check("wb_beat", {bus.wb_data_last, bus.wb_data}, exp_wb_beat.pop_front());
                else extra("wb_beat_unexpected", {bus.wb_data_last, bus.wb_data});
            end
            pend_wd = bus.wb_data_valid && !bus.wb_data_ready;
            hold_wd = {bus.wb_data_last, bus.wb_data};

            if (bus.rd_req_valid && bus.rd_req_ready) begin
                rd_count++;
                if (exp_rd.size() > 0) check("rd_req_addr", bus.rd_req_addr, exp_rd.pop_front());
                else extra("rd_req_unexpected", bus.rd_req_addr);
            end
            pend_rd = bus.rd_req_valid && !bus.rd_req_ready;
            hold_rd = bus.rd_req_addr;

            if (refill_we) begin
                if (exp_refill.size() > 0)
                    check("refill", {refill_way, refill_index, refill_word, refill_data, tag_we}, exp_refill.pop_front());
                else extra("refill_unexpected", {refill_way, refill_index, refill_word, refill_data, tag_we});
            end else if (tag_we) extra("tag_we_without_refill", tag_we);

            if (refill_we4) check("refill_way_4w", refill_way4, exp_way4);

            if (repl_update) begin
                if (exp_hit.size() > 0) check("repl_hit", repl_hit, exp_hit.pop_front());
                else extra("repl_update_unexpected", repl_hit);
            end else if (repl_hit != 2'b00) extra("repl_hit_idle", repl_hit);

            if (repl_update4) begin
                if (exp_hit4.size() > 0) check("repl_hit_4w", repl_hit4, exp_hit4.pop_front());
                else extra("repl_update_4w_unexpected", repl_hit4);
            end

            if (lat == 1) begin
                check("done_cycle", {repl_update, miss_ready}, 2'b10);
                lat = 2;
            end else if (lat == 2) begin
                check("ready_after_done", {repl_update, miss_ready}, 2'b01);
                lat = 0;
            end
            if (refill_we && tag_we) lat = 1;

            if (bus.rd_req_valid || bus4.rd_req_valid || repl_update || repl_update4)
                check("lockstep_4w_bus",
                      {bus4.wb_addr_valid, bus4.wb_addr, bus4.wb_data_valid, bus4.wb_data, bus4.wb_data_last,
                       bus4.rd_req_valid, bus4.rd_req_addr, miss_ready4, refill_we4, refill_word4, tag_we4, repl_update4},
                      {bus.wb_addr_valid, bus.wb_addr, bus.wb_data_valid, bus.wb_data, bus.wb_data_last,
                       bus.rd_req_valid, bus.rd_req_addr, miss_ready, refill_we, refill_word, tag_we, repl_update});
            if (refill_we4)
                check("lockstep_4w_refill", {refill_index4, refill_data4}, {refill_index, refill_data});
        end
    end

    // Ready generation: 0 = always ready, 1 = scripted backpressure, 2 = random.
    int mode = 0;
    int bp_k = 0;
    int rdv_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (bus.rd_req_valid) rdv_cnt++; else rdv_cnt = 0;
        case (mode)
            0: begin
                bus.wb_addr_ready = 1'b1;
                bus.wb_data_ready = 1'b1;
                bus.rd_req_ready  = 1'b1;
            end
            1: begin
                bus.wb_addr_ready = 1'($urandom_range(0, 1));
                bus.wb_data_ready = (bp_k % 4 == 0) || (bp_k % 4 == 3);
                bp_k++;
                bus.rd_req_ready  = (rdv_cnt > 3);
            end
            default: begin
                bus.wb_addr_ready = 1'($urandom_range(0, 1));
                bus.wb_data_ready = 1'($urandom_range(0, 1));
                bus.rd_req_ready  = 1'($urandom_range(0, 1));
            end
        endcase
    end

    task automatic wait_miss_ready();
        bit ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (miss_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) extra("miss_ready_timeout", miss_ready);
    endtask

    // ret_base/line_base < 0 select random data; gap < 0 selects random 0..2 idle cycles per beat.
    task automatic do_miss(input logic [31:0] addr, input logic way, input logic [1:0] way4,
                           input logic dirty, input logic [19:0] vtag,
                           input int line_base, input int ret_base, input int gap, input bit reset_mid);
        logic [31:0] words [LW];
        logic [31:0] line  [LW];
        logic [31:0] idx;
        int          start;
        int          t;

        idx = (addr >> 5) & 32'h7F;
        for (int i = 0; i < LW; i++) begin
            line[i]  = (line_base < 0) ? $urandom : 32'(line_base + i);
            words[i] = (ret_base < 0) ? $urandom : 32'(ret_base + i);
        end

        wait_miss_ready();
        if (dirty) begin
            exp_wb_addr.push_back((32'(vtag) << 12) | (idx << 5));
            for (int i = 0; i < LW; i++) exp_wb_beat.push_back({(i == LW - 1), line[i]});
        end
        exp_rd.push_back(addr & 32'hFFFF_FFE0);
        for (int i = 0; i < LW; i++) exp_refill.push_back({way, idx[6:0], 3'(i), words[i], (i == LW - 1)});
        exp_hit.push_back(2'b01 << way);
        exp_hit4.push_back(4'b0001 << way4);
        exp_way4 = way4;

        miss_valid   = 1'b1;
        miss_addr    = addr;
        plru         = way;
        plru4        = way4;
        victim_tag   = vtag;
        victim_dirty = dirty;
        for (int i = 0; i < LW; i++) victim_line[i*32 +: 32] = line[i];
        start = rd_count;
        t = wb_count;

        // Keep a junk miss asserted for one busy cycle; it must not be taken.
        @(posedge clk);
        #1;
        miss_addr    = $urandom;
        victim_dirty = 1'($urandom_range(0, 1));
        plru         = ~way;
        @(posedge clk);
        #1 miss_valid = 1'b0;

        if (reset_mid) begin
            for (int k = 0; k < 200 && wb_count < t + 3; k++) @(posedge clk);
            if (wb_count < t + 3) extra("wb_beat3_timeout", wb_count - t);
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            exp_wb_addr.delete();
            exp_wb_beat.delete();
            exp_rd.delete();
            exp_refill.delete();
            exp_hit.delete();
            exp_hit4.delete();
            @(negedge clk);
            check("idle_after_reset",
                  {miss_ready, bus.wb_addr_valid, bus.wb_data_valid, bus.rd_req_valid, refill_we, tag_we,
                   repl_update, repl_hit, refill_word},
                  {1'b1, 6'b0, 2'b00, 3'd0});
            return;
        end

        for (int k = 0; k < 400 && rd_count == start; k++) @(posedge clk);
        if (rd_count == start) extra("rd_req_timeout", bus.rd_req_valid);

        for (int i = 0; i < LW; i++) begin
            int g;
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            repeat (g) @(posedge clk);
            #1;
            bus.ret_valid = 1'b1;
            bus.ret_data  = words[i];
            bus.ret_last  = (i == LW - 1);
            @(posedge clk);
            #1;
            bus.ret_valid = 1'b0;
            bus.ret_last  = 1'b0;
            bus.ret_data  = $urandom;
        end

        wait_miss_ready();
        check("queues_drained",
              exp_wb_addr.size() + exp_wb_beat.size() + exp_rd.size() + exp_refill.size() +
              exp_hit.size() + exp_hit4.size(), 0);
    endtask

    initial begin
        bus.wb_addr_ready = 1'b0;
        bus.wb_data_ready = 1'b0;
        bus.rd_req_ready  = 1'b0;
        bus.ret_valid     = 1'b0;
        bus.ret_data      = '0;
        bus.ret_last      = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state",
              {miss_ready, bus.wb_addr_valid, bus.wb_data_valid, bus.rd_req_valid, refill_we, tag_we,
               repl_update, repl_hit, refill_word, repl_hit4},
              {1'b1, 6'b0, 2'b00, 3'd0, 4'b0000});
        @(posedge clk);
        #1 reset = 1'b0;

        mode = 0;
        do_miss(32'h0000_1A40, 1'b1, 2'd2, 1'b0, 20'h0, -1, 32'h100, 0, 1'b0);
        do_miss(32'hABCD_E200, 1'b0, 2'd1, 1'b1, 20'h12345, 32'hA0, -1, 0, 1'b0);

        mode = 1;
        bp_k = 0;
        do_miss($urandom, 1'b0, 2'd3, 1'b1, 20'($urandom), -1, -1, 0, 1'b0);
        do_miss($urandom, 1'b1, 2'd0, 1'b1, 20'($urandom), -1, -1, 1, 1'b0);

        mode = 0;
        do_miss($urandom, 1'b1, 2'd2, 1'b0, 20'h0, -1, -1, 2, 1'b0);

        do_miss(32'h0F0F_0A60, 1'b0, 2'd1, 1'b1, 20'hC0FFE, -1, -1, 0, 1'b1);
        do_miss(32'h0000_3FE0, 1'b0, 2'd2, 1'b0, 20'h0, -1, 32'h200, 0, 1'b0);

        mode = 2;
        for (int n = 0; n < 25; n++)
            do_miss($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 20'($urandom), -1, -1, -1, 1'b0);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end
endmodule
